// File: rtl/rob_id_alloc.sv
// ----------------------------------------------------------------------------
// rob_id_alloc : reorder-buffer ID allocator with in-order commit and flush
//                rollback of the allocation pointer.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rob_id_alloc #(
   parameter int ROB_SIZE   = 16,
   parameter int RSID_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_req,
   output logic                  alloc_grant,
   output logic [RSID_WIDTH-1:0] alloc_rsid,
   output logic                  stall_id,
   input  logic                  commit_en,
   input  logic [RSID_WIDTH-1:0] commit_rsid,
   input  logic                  flush_en,
   input  logic [RSID_WIDTH-1:0] flush_rsid,
   output logic [RSID_WIDTH-1:0] head_rsid,
   output logic [RSID_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  commit_error
);

   localparam logic [RSID_WIDTH:0] c_rob_size = (RSID_WIDTH+1)'(ROB_SIZE);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [RSID_WIDTH:0]   head_q, head_d;
   logic [RSID_WIDTH:0]   tail_q, tail_d;
   logic                  commit_error_q, commit_error_d;

   logic [RSID_WIDTH:0]   w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_grant;
   logic                  w_commit_ok;
   logic [RSID_WIDTH-1:0] w_off;
   logic                  w_flush_ok;
   logic                  w_flush_head;

   always_comb begin
      w_count      = tail_q - head_q;
      w_full       = (w_count == c_rob_size);
      w_empty      = (head_q == tail_q);
      w_grant      = alloc_req && !w_full && !flush_en;
      w_commit_ok  = commit_en && !w_empty && (commit_rsid == head_q[RSID_WIDTH-1:0]);
      w_off        = flush_rsid - head_q[RSID_WIDTH-1:0];
      w_flush_ok   = flush_en && ({1'b0, w_off} < w_count);
      // A flush of the head entry squashes the instruction being committed.
      w_flush_head = w_flush_ok && (w_off == '0);
   end

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      commit_error_d = commit_en && !w_commit_ok;

      if (w_commit_ok && !w_flush_head) begin
         head_d = head_q + 1'b1;
      end

      if (w_flush_ok) begin
         tail_d = head_q + {1'b0, w_off};
      end else if (w_grant) begin
         tail_d = tail_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         commit_error_q <= 1'b0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         commit_error_q <= commit_error_d;
      end
   end

   assign alloc_grant  = w_grant;
   assign alloc_rsid   = tail_q[RSID_WIDTH-1:0];
   assign stall_id     = alloc_req && !w_grant;
   assign head_rsid    = head_q[RSID_WIDTH-1:0];
   assign count        = w_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign commit_error = commit_error_q;

endmodule

`default_nettype wire

// File: tb/tb_rob_id_alloc.sv
// ----------------------------------------------------------------------------
// tb_rob_id_alloc : table-driven directed bench for rob_id_alloc.
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rob_id_alloc;

   logic       clk;
   logic       rst;
   logic       alloc_req;
   logic       alloc_grant;
   logic [3:0] alloc_rsid;
   logic       stall_id;
   logic       commit_en;
   logic [3:0] commit_rsid;
   logic       flush_en;
   logic [3:0] flush_rsid;
   logic [3:0] head_rsid;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       commit_error;

   rob_id_alloc #(
      .ROB_SIZE   (16),
      .RSID_WIDTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_grant  (alloc_grant),
      .alloc_rsid   (alloc_rsid),
      .stall_id     (stall_id),
      .commit_en    (commit_en),
      .commit_rsid  (commit_rsid),
      .flush_en     (flush_en),
      .flush_rsid   (flush_rsid),
      .head_rsid    (head_rsid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .commit_error (commit_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expectations describe outputs seen during the cycle the inputs are applied,
   // i.e. registered outputs show the state left by the previous vector.
   typedef struct {
      logic       rst;
      logic       req;
      logic       cen;
      logic [3:0] crsid;
      logic       fen;
      logic [3:0] frsid;
      logic       grant;
      logic [3:0] rsid;
      logic       stall;
      logic [3:0] head;
      logic [4:0] cnt;
      logic       full;
      logic       empty;
      logic       err;
   } vec_t;

   vec_t vq[$];
   int   n_checks;
   int   n_pass;

   task automatic add(input logic r, input logic rq, input logic ce, input logic [3:0] cr,
                      input logic fe, input logic [3:0] fr,
                      input logic g, input logic [3:0] rs, input logic st, input logic [3:0] hd,
                      input logic [4:0] cn, input logic fu, input logic em, input logic er);
      vec_t v;
      v.rst = r;  v.req = rq;  v.cen = ce;  v.crsid = cr;  v.fen = fe;  v.frsid = fr;
      v.grant = g; v.rsid = rs; v.stall = st; v.head = hd; v.cnt = cn;
      v.full = fu; v.empty = em; v.err = er;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (grant,rsid,stall,head,count,full,empty,err)",
                    name, act, exp);
   endtask

   function automatic logic [17:0] outs();
      return {alloc_grant, alloc_rsid, stall_id, head_rsid, count, full, empty, commit_error};
   endfunction

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst         = 1'b1;
      alloc_req   = 1'b0;
      commit_en   = 1'b0;
      commit_rsid = 4'd0;
      flush_en    = 1'b0;
      flush_rsid  = 4'd0;

      // ---- fill: 16 grants 0..15, then full and stalled
      for (int i = 0; i < 16; i++)
         add(0, 1, 0, 0, 0, 0, 1, 4'(i), 0, 0, 5'(i), 0, (i == 0), 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 16, 1, 0, 0);
      // ---- full + commit 0: no bypass; next cycle grants wrapped RSID 0
      add(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 16, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 15, 0, 0, 0);
      // ---- reset, build count 5, rejected and accepted commits
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16, 1, 0, 0);
      for (int i = 0; i < 5; i++)
         add(0, 1, 0, 0, 0, 0, 1, 4'(i), 0, 0, 5'(i), 0, (i == 0), 0);
      add(0, 0, 1, 3, 0, 0, 0, 5, 0, 0, 5, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 5, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 4, 0, 0, 0);
      // ---- reach head 2 / tail 9
      add(0, 1, 1, 1, 0, 0, 1, 5, 0, 1, 4, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         add(0, 1, 0, 0, 0, 0, 1, 4'(6 + i), 0, 2, 5'(4 + i), 0, 0, 0);
      // flush 5 with request: accepted, not granted
      add(0, 1, 0, 0, 1, 5, 0, 9, 1, 2, 7, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 5, 0, 2, 3, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         add(0, 1, 0, 0, 0, 0, 1, 4'(5 + i), 0, 2, 5'(3 + i), 0, 0, 0);
      // flush 12 is beyond tail: ignored
      add(0, 0, 0, 0, 1, 12, 0, 9, 0, 2, 7, 0, 0, 0);
      // commit 2 + flush 6: head 3, tail 6
      add(0, 0, 1, 2, 1, 6, 0, 9, 0, 2, 7, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 6, 0, 3, 3, 0, 0, 0);
      // ---- rebuild head 2 / tail 9, then commit 2 + flush 2
      add(1, 0, 0, 0, 0, 0, 0, 6, 0, 3, 3, 0, 0, 0);
      for (int i = 0; i < 9; i++)
         add(0, 1, 0, 0, 0, 0, 1, 4'(i), 0, 0, 5'(i), 0, (i == 0), 0);
      add(0, 0, 1, 0, 0, 0, 0, 9, 0, 0, 9, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 9, 0, 1, 8, 0, 0, 0);
      add(0, 1, 1, 2, 1, 2, 0, 9, 1, 2, 7, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 1, 0);
      // ---- count 8, then 20 cycles of alloc + commit across the wrap
      for (int i = 0; i < 8; i++)
         add(0, 1, 0, 0, 0, 0, 1, 4'(2 + i), 0, 2, 5'(i), 0, (i == 0), 0);
      for (int j = 0; j < 20; j++)
         add(0, 1, 1, 4'((2 + j) % 16), 0, 0, 1, 4'((10 + j) % 16), 0,
             4'((2 + j) % 16), 8, 0, 0, 0);
      // mid-run reset with a bad commit pending: no error pulse afterwards
      add(1, 1, 1, 3, 0, 0, 1, 14, 0, 6, 8, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #2;
      check("reset_state", outs(), {1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0});

      for (int k = 0; k < vq.size(); k++) begin
         if (k != 0) @(negedge clk);
         rst         = vq[k].rst;
         alloc_req   = vq[k].req;
         commit_en   = vq[k].cen;
         commit_rsid = vq[k].crsid;
         flush_en    = vq[k].fen;
         flush_rsid  = vq[k].frsid;
         #2;
         check($sformatf("vec%0d", k), outs(),
               {vq[k].grant, vq[k].rsid, vq[k].stall, vq[k].head, vq[k].cnt,
                vq[k].full, vq[k].empty, vq[k].err});
      end

      // Hand sequence: single entry, flush of the head itself empties the buffer.
      @(negedge clk);
      rst = 1'b0; alloc_req = 1'b1; commit_en = 1'b0; flush_en = 1'b0;
      #2;
      check("hs_alloc", outs(), {1'b1, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      alloc_req = 1'b0; flush_en = 1'b1; flush_rsid = 4'd0;
      #2;
      check("hs_flush_head", outs(), {1'b0, 4'd1, 1'b0, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      flush_en = 1'b0; commit_en = 1'b1; commit_rsid = 4'd0;
      #2;
      check("hs_empty_after_flush", outs(), {1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      commit_en = 1'b0;
      #2;
      check("hs_commit_on_empty_err", outs(), {1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
